uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shared 8N1 UART transmitter with round-robin arbitration between `n_src` byte producers. Message generators, debug printers and the CPU console each present bytes through a req/ack handshake. This block grants one byte at a time and serializes it on the single `tx` pin. A per-source `hold` input lets a producer keep ownership so a multi-byte message is not interleaved with other sources.

## Interface
Parameters:
- `clk_freq`, 1000000: clock frequency in Hz.
- `baud_rate`, 9600: line rate. Cycles per bit `cpb = clk_freq / baud_rate` (integer division, truncated). `cpb` must be ≥ 2.
- `n_src`, 4: number of requesters, 2..16.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  `n_src`  bit i: source i has a byte on its data slice.
- `hold`  in  `n_src`  bit i: source i requests to keep ownership after its current byte.
- `data`  in  `8*n_src`  source i byte at `data[8*i+7:8*i]`; must be stable while `req[i]` is high.
- `ack`  out  `n_src`  one-cycle pulse: the byte of source i was captured.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is on the line (START, DATA, STOP states).

## Operation
- FSM states: IDLE, START, DATA, STOP. Registers:
  - `shreg[7:0]`
  - `bitcnt[2:0]`
  - `baudcnt` of width `$clog2(cpb)`
  - `last[$clog2(n_src)-1:0]`
  - `locked`
  - `owner`
- Reset values: state = IDLE, `tx` = 1, `ack` = 0, `busy` = 0, `locked` = 0, `owner` = 0, `last` = `n_src-1`. Source 0 therefore wins the first round-robin search.
- Arbitration is evaluated only in IDLE.
  - Not locked: the winner is the first i with `req[i]=1`, searching `last+1, last+2, …` modulo `n_src`.
  - Locked: only `owner` is eligible. If `req[owner]=0`, no grant is made and the block waits in IDLE; other sources are ignored.
  - Lock release: in IDLE with `locked=1` and `hold[owner]=0`, `locked` clears. Normal round-robin applies in that same cycle.
- On a grant to source w (IDLE edge):
  - `shreg <= data[w]`, `ack[w] <= 1` for exactly one cycle.
  - `last <= w`, `owner <= w`, `locked <= hold[w]`.
  - state <= START, `baudcnt <= 0`.
- Frame (LSB first):
  - START drives `tx=0` for `cpb` cycles.
  - DATA drives `tx=shreg[0]` for `cpb` cycles per bit. `shreg` shifts right and `bitcnt` increments at each bit end; after bit 7, go to STOP.
  - STOP drives `tx=1` for `cpb` cycles, then returns to IDLE.
- `tx` and `busy` are registered outputs with no combinational path from inputs.
- `req`/`hold` changes during START/DATA/STOP have no effect. Only values sampled in IDLE matter.
- Reset asserted mid-frame: on the next edge all registers take their reset values. `tx` returns high immediately, which truncates the frame, and no `ack` is issued.

## Timing
- Grant latency: `req[i]` high in IDLE at edge k (eligible and winning) gives `ack[i]` high during cycle k+1 and `tx` falling during cycle k+1.
- Frame length: exactly `10*cpb` cycles from the `tx` fall to the return to IDLE.
- One IDLE cycle between frames, so the continuous-request period is `10*cpb + 1` cycles.
- A source that keeps `req` high after `ack` must present its next byte on the cycle after `ack`. The next sample point is at least `10*cpb` cycles later.
- `ack` never pulses for two sources in the same cycle, and never for more than one cycle per byte.

## Test plan
All scenarios use `clk_freq=1000000`, `baud_rate=100000` (`cpb=10`), `n_src=4`.
- Single byte: `req[2]=1`, `data[2]=8'hA5` → `ack[2]` pulses 1 cycle after the sample. `tx` shows 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop), 10 cycles each. `busy` is high 100 cycles.
- Round robin: all `req` high continuously, distinct bytes 8'h10..8'h13 → grant order 0,1,2,3,0. Frame starts are 101 cycles apart.
- Hold: source 1 sends 3 bytes with `hold[1]=1` while `req[3]` is high throughout → three consecutive frames from source 1. Drop `hold[1]` → source 3 is next.
- Locked wait: `hold[0]=1` after its grant, `req[0]` low for 500 cycles, `req[2]` high → no frame and no `ack[2]` until `req[0]` returns or `hold[0]` falls.
- Reset mid-frame: assert `reset` during DATA bit 4 → `tx=1`, `busy=0`, `ack=0` after the edge. After release, a pending `req[3]` alone is granted first, because the search starts from 0.
- Back-to-back same source: `req[0]` held with data changing on each `ack` (8'h00, 8'hFF) → both bytes decode correctly and no byte is duplicated.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shared 8N1 UART transmitter with round-robin arbitration
// between n_src byte producers, with per-source ownership hold.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line high; arbitrate and capture the winning byte
// ST_START | start bit (tx=0) for cpb cycles
// ST_DATA  | eight data bits LSB first, cpb cycles each
// ST_STOP  | stop bit (tx=1) for cpb cycles, then back to idle
module uart_tx_arbiter #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600,
    parameter int n_src     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [n_src-1:0]     req,
    input  logic [n_src-1:0]     hold,
    input  logic [8*n_src-1:0]   data,
    output logic [n_src-1:0]     ack,
    output logic                 tx,
    output logic                 busy
);

    localparam int cpb = clk_freq / baud_rate;
    localparam int bcw = (cpb > 1) ? $clog2(cpb) : 1;
    localparam int sw  = $clog2(n_src);
    localparam logic [bcw-1:0] baud_last = bcw'(cpb - 1);
    localparam logic [sw-1:0]  last_rst  = sw'(n_src - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [bcw-1:0]   baudcnt_q, baudcnt_d;
    logic [sw-1:0]    last_q, last_d;
    logic             locked_q, locked_d;
    logic [sw-1:0]    owner_q, owner_d;
    logic [n_src-1:0] ack_q, ack_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic             rr_found;
    logic [sw-1:0]    rr_win;
    logic [sw-1:0]    rr_cand;
    int               rr_idx;

    logic             locked_eff;
    logic             grant;
    logic [sw-1:0]    win;
    logic             baud_end;

    // Round-robin search: first requester after last_q, wrapping modulo n_src.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_idx   = 0;
        rr_cand  = '0;
        for (int k = 1; k <= n_src; k++) begin
            rr_idx  = (int'(last_q) + k) % n_src;
            rr_cand = sw'(rr_idx);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_win   = rr_cand;
            end
        end
    end

    // Next-state, grant and frame sequencing; tx/busy are computed here and registered.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        baudcnt_d  = baudcnt_q;
        last_d     = last_q;
        locked_d   = locked_q;
        owner_d    = owner_q;
        ack_d      = '0;
        tx_d       = tx_q;
        busy_d     = busy_q;
        locked_eff = 1'b0;
        grant      = 1'b0;
        win        = '0;
        baud_end   = (baudcnt_q == baud_last);

        case (state_q)
            ST_IDLE: begin
                // A lock only survives while the owner keeps hold asserted.
                locked_eff = locked_q && hold[owner_q];
                locked_d   = locked_eff;
                if (locked_eff) begin
                    grant = req[owner_q];
                    win   = owner_q;
                end else begin
                    grant = rr_found;
                    win   = rr_win;
                end
                if (grant) begin
                    shreg_d    = data[{win, 3'b000} +: 8];
                    ack_d[win] = 1'b1;
                    last_d     = win;
                    owner_d    = win;
                    locked_d   = hold[win];
                    state_d    = ST_START;
                    baudcnt_d  = '0;
                    bitcnt_d   = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baudcnt_d = '0;
                    state_d   = ST_DATA;
                    tx_d      = shreg_q[0];
                end else begin
                    baudcnt_d = baudcnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baudcnt_d = '0;
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bitcnt_d  = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baudcnt_d = baudcnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baudcnt_d = '0;
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                end else begin
                    baudcnt_d = baudcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset truncates any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            baudcnt_q <= '0;
            last_q    <= last_rst;
            locked_q  <= 1'b0;
            owner_q   <= '0;
            ack_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            baudcnt_q <= baudcnt_d;
            last_q    <= last_d;
            locked_q  <= locked_d;
            owner_q   <= owner_d;
            ack_q     <= ack_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign ack  = ack_q;
    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
